// File: rtl/sample_queue.sv
//------------------------------------------------------------------------------
// Module      : sample_queue
// Description : Stereo sample circular buffer that replays a sliding window of
//               the most recent TAPS samples, oldest first, to a FIR filter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sample_queue #(
    parameter int DEPTH = 1024,
    parameter int TAPS  = 1021
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [15:0] lft_smpl,
    input  logic signed [15:0] rght_smpl,
    input  logic               wrt_smpl,
    output logic signed [15:0] lft_out,
    output logic signed [15:0] rght_out,
    output logic               sequencing,
    output logic               overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TAPS + 1);

    localparam logic [CW-1:0] c_taps     = CW'(TAPS);
    localparam logic [CW-1:0] c_last_idx = CW'(TAPS - 1);

    typedef logic [AW-1:0] ptr_t;
    typedef enum logic [1:0] {FILL, IDLE, PRIME, SEQ} state_t;

    state_t        state_q,      state_d;
    ptr_t          new_ptr_q,    new_ptr_d;
    ptr_t          old_ptr_q,    old_ptr_d;
    logic [CW-1:0] count_q,      count_d;
    logic [CW-1:0] idx_q,        idx_d;
    logic          pending_q,    pending_d;
    logic          overflow_q,   overflow_d;
    logic          sequencing_q, sequencing_d;
    logic [31:0]   out_q,        out_d;

    logic [31:0]   mem_q [DEPTH];

    logic          w_busy;
    logic          w_last;
    logic          w_wr_ok;
    logic          w_rd_en;
    ptr_t          w_rd_addr;

    always_comb begin
        w_busy    = (state_q == PRIME) || (state_q == SEQ);
        w_last    = (state_q == SEQ) && (idx_q == c_last_idx);
        // On the last window cycle the pending slot frees up, so a write is accepted.
        w_wr_ok   = wrt_smpl && (!w_busy || !pending_q || w_last);
        w_rd_en   = (state_q == PRIME) || ((state_q == SEQ) && !w_last);
        w_rd_addr = (state_q == SEQ) ? old_ptr_q + ptr_t'(idx_q) + ptr_t'(1) : old_ptr_q;

        state_d    = state_q;
        new_ptr_d  = new_ptr_q;
        old_ptr_d  = old_ptr_q;
        count_d    = count_q;
        idx_d      = idx_q;
        pending_d  = pending_q;
        overflow_d = overflow_q;

        if (w_wr_ok) begin
            new_ptr_d = new_ptr_q + ptr_t'(1);
            if (count_q != c_taps) begin
                count_d = count_q + CW'(1);
            end
        end
        if (wrt_smpl && !w_wr_ok) begin
            overflow_d = 1'b1;
        end

        case (state_q)
            FILL: begin
                if (w_wr_ok && (count_q == c_last_idx)) begin
                    state_d = PRIME;
                end
            end
            IDLE: begin
                if (w_wr_ok) begin
                    state_d = PRIME;
                end
            end
            PRIME: begin
                state_d = SEQ;
                idx_d   = '0;
                if (w_wr_ok) begin
                    pending_d = 1'b1;
                end
            end
            SEQ: begin
                if (w_last) begin
                    old_ptr_d = old_ptr_q + ptr_t'(1);
                    idx_d     = '0;
                    // A write landing now is already inside the next window.
                    state_d   = (pending_q || w_wr_ok) ? PRIME : IDLE;
                    pending_d = pending_q && w_wr_ok;
                end else begin
                    idx_d = idx_q + CW'(1);
                    if (w_wr_ok) begin
                        pending_d = 1'b1;
                    end
                end
            end
            default: state_d = FILL;
        endcase

        sequencing_d = (state_d == SEQ);
        out_d        = w_rd_en ? mem_q[w_rd_addr] : out_q;
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            mem_q[new_ptr_q] <= {lft_smpl, rght_smpl};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FILL;
            new_ptr_q    <= '0;
            old_ptr_q    <= '0;
            count_q      <= '0;
            idx_q        <= '0;
            pending_q    <= 1'b0;
            overflow_q   <= 1'b0;
            sequencing_q <= 1'b0;
            out_q        <= '0;
        end else begin
            state_q      <= state_d;
            new_ptr_q    <= new_ptr_d;
            old_ptr_q    <= old_ptr_d;
            count_q      <= count_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            overflow_q   <= overflow_d;
            sequencing_q <= sequencing_d;
            out_q        <= out_d;
        end
    end

    assign lft_out    = out_q[31:16];
    assign rght_out   = out_q[15:0];
    assign sequencing = sequencing_q;
    assign overflow   = overflow_q;

endmodule

`default_nettype wire
